cpx_accumulate_dump: RTL

- Complex integrate-and-dump stage directly downstream of cpx_multiply in the CAF correlation path.
- Consumes the i_out/q_out product stream and sums LENGTH consecutive accepted products per frame.
- Emits one full-precision complex sum per frame to the next stage (magnitude/peak search) over valid/ready handshakes.

---
 rtl/cpx_accumulate_dump.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cpx_accumulate_dump.sv
// cpx_accumulate_dump: complex integrate-and-dump.
// Sums LENGTH accepted I/Q products per frame and emits one full-precision
// complex sum per frame over a valid/ready handshake.
// Optional: define CPX_ACCUM_MAG_EN to add mag_out = |i_sum| + |q_sum|.
module cpx_accumulate_dump #(
  parameter int I_BITS     = 25,
  parameter int Q_BITS     = 25,
  parameter int LENGTH     = 8,
  parameter int I_ACC_BITS = I_BITS + $clog2(LENGTH),
  parameter int Q_ACC_BITS = Q_BITS + $clog2(LENGTH)
`ifdef CPX_ACCUM_MAG_EN
  ,
  parameter int MAG_BITS   = ((I_ACC_BITS > Q_ACC_BITS) ? I_ACC_BITS : Q_ACC_BITS) + 1
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [I_BITS-1:0]     i_in,
  input  logic signed [Q_BITS-1:0]     q_in,
  input  logic                         m_axis_tvalid,
  output logic                         m_axis_tready,
  output logic signed [I_ACC_BITS-1:0] i_out,
  output logic signed [Q_ACC_BITS-1:0] q_out,
`ifdef CPX_ACCUM_MAG_EN
  output logic [MAG_BITS-1:0]          mag_out,
`endif
  output logic                         s_axis_tvalid,
  input  logic                         s_axis_tready
);

  // count needs at least one bit even when LENGTH == 1
  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

  typedef enum logic {ST_ACCUM, ST_LAST} state_t;
  // a one-beat frame is always on its final beat
  localparam state_t ST_RESET = (LENGTH == 1) ? ST_LAST : ST_ACCUM;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic signed [I_ACC_BITS-1:0]  acc_i_q, acc_i_d;
  logic signed [Q_ACC_BITS-1:0]  acc_q_q, acc_q_d;
  logic signed [I_ACC_BITS-1:0]  i_out_q, i_out_d;
  logic signed [Q_ACC_BITS-1:0]  q_out_q, q_out_d;
  logic                          vld_q, vld_d;
  logic signed [I_ACC_BITS-1:0]  i_ext, sum_i;
  logic signed [Q_ACC_BITS-1:0]  q_ext, sum_q;
  logic                          accept;

`ifdef CPX_ACCUM_MAG_EN
  logic [MAG_BITS-1:0] mag_q, mag_d;

  // Extra top bit lets |most negative| be represented exactly.
  function automatic logic [MAG_BITS-1:0] abs_ext(input logic signed [MAG_BITS-1:0] v);
    return v[MAG_BITS-1] ? -v : v;
  endfunction
`endif

  // Sign-extend the products; accumulator width covers LENGTH worst-case beats.
  assign i_ext = I_ACC_BITS'(i_in);
  assign q_ext = Q_ACC_BITS'(q_in);
  assign sum_i = acc_i_q + i_ext;
  assign sum_q = acc_q_q + q_ext;

  // Stall only the final beat of a frame while the previous sum is still unconsumed.
  assign m_axis_tready = !(state_q == ST_LAST && vld_q && !s_axis_tready);
  assign accept        = m_axis_tvalid && m_axis_tready;

  assign i_out         = i_out_q;
  assign q_out         = q_out_q;
  assign s_axis_tvalid = vld_q;
`ifdef CPX_ACCUM_MAG_EN
  assign mag_out       = mag_q;
`endif

  // Next-state: accumulate on ACCUM beats, dump on the LAST beat.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    i_out_d = i_out_q;
    q_out_d = q_out_q;
    vld_d   = vld_q && !s_axis_tready;
`ifdef CPX_ACCUM_MAG_EN
    mag_d   = mag_q;
`endif
    if (accept) begin
      if (state_q == ST_LAST) begin
        // a new load on the same edge as a consume keeps valid high
        i_out_d = sum_i;
        q_out_d = sum_q;
        vld_d   = 1'b1;
`ifdef CPX_ACCUM_MAG_EN
        mag_d   = abs_ext(MAG_BITS'(sum_i)) + abs_ext(MAG_BITS'(sum_q));
`endif
        acc_i_d = '0;
        acc_q_d = '0;
        count_d = '0;
        state_d = ST_RESET;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        count_d = count_q + CNT_W'(1);
        state_d = (count_d == LAST_CNT) ? ST_LAST : ST_ACCUM;
      end
    end
  end

  // State registers; reset wins over a simultaneous accept and drops any pending sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      count_q <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      i_out_q <= '0;
      q_out_q <= '0;
      vld_q   <= 1'b0;
`ifdef CPX_ACCUM_MAG_EN
      mag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
      vld_q   <= vld_d;
`ifdef CPX_ACCUM_MAG_EN
      mag_q   <= mag_d;
`endif
    end
  end

endmodule
